// File: rtl/bcd_seg7_scanner.sv
// Three-digit multiplexed common-anode seven-segment driver for packed BCD.
// Double-buffers incoming digits so updates only land on frame boundaries.
module bcd_seg7_scanner #(
  parameter int unsigned REFRESH_DIV      = 100000,
  parameter bit          BLANK_LZ_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        load,
  input  logic        blank_lz_wr,
  input  logic        blank_lz_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [11:0]     pending_q, pending_d;
  logic            pending_valid_q, pending_valid_d;
  logic [11:0]     disp_q, disp_d;
  logic            blank_lz_q, blank_lz_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      an_q, an_d;

  logic tick;
  logic boundary;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h3F; // nibble above 9: dash
    endcase
    return g;
  endfunction

  assign tick     = (div_cnt_q == CntMax);
  assign boundary = tick && (idx_q == DIG2);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    idx_d = idx_q;
    case (idx_q)
      DIG0:    if (tick) idx_d = DIG1;
      DIG1:    if (tick) idx_d = DIG2;
      DIG2:    if (tick) idx_d = DIG0;
      default: idx_d = DIG0;
    endcase
  end

  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    disp_d          = disp_q;
    if (boundary) begin
      // A load coinciding with the boundary skips the pending buffer entirely.
      if (load) begin
        disp_d = bcd;
      end else if (pending_valid_q) begin
        disp_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = bcd;
      pending_valid_d = 1'b1;
    end
    blank_lz_d = blank_lz_wr ? blank_lz_in : blank_lz_q;
  end

  always_comb begin
    logic [3:0] hun, ten, one;
    hun  = disp_q[11:8];
    ten  = disp_q[7:4];
    one  = disp_q[3:0];
    seg_d = glyph(one);
    an_d  = 3'b110;
    case (idx_q)
      DIG1: begin
        an_d  = 3'b101;
        seg_d = (blank_lz_q && hun == 4'd0 && ten == 4'd0) ? 7'h7F : glyph(ten);
      end
      DIG2: begin
        an_d  = 3'b011;
        seg_d = (blank_lz_q && hun == 4'd0) ? 7'h7F : glyph(hun);
      end
      default: begin
        an_d  = 3'b110;
        seg_d = glyph(one);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q       <= '0;
      idx_q           <= DIG0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      disp_q          <= '0;
      blank_lz_q      <= BLANK_LZ_DEFAULT;
      seg_q           <= 7'h7F;
      an_q            <= 3'b111;
    end else begin
      div_cnt_q       <= div_cnt_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      blank_lz_q      <= blank_lz_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Directed bench for bcd_seg7_scanner with a 4-cycle digit slot (12-cycle frame).
module tb_bcd_seg7_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd = '0;
  logic        load = 1'b0;
  logic        blank_lz_wr = 1'b0;
  logic        blank_lz_in = 1'b0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bcd_seg7_scanner #(
    .REFRESH_DIV     (4),
    .BLANK_LZ_DEFAULT(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd        (bcd),
    .load       (load),
    .blank_lz_wr(blank_lz_wr),
    .blank_lz_in(blank_lz_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [2:0] a_exp, input logic [6:0] s_exp);
    total++;
    assert (an === a_exp) else begin
      bad++;
      $error("FAIL %s an got=%b exp=%b (cyc %0d)", tag, an, a_exp, cyc);
    end
    total++;
    assert (seg === s_exp) else begin
      bad++;
      $error("FAIL %s seg got=%h exp=%h (cyc %0d)", tag, seg, s_exp, cyc);
    end
  endtask

  task automatic chk_fd(input string tag, input logic f_exp);
    total++;
    assert (frame_done === f_exp) else begin
      bad++;
      $error("FAIL %s frame_done got=%b exp=%b (cyc %0d)", tag, frame_done, f_exp, cyc);
    end
  endtask

  initial begin
    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 3'b111, 7'h7F);
    chk_fd("reset_fd", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Idle scan: 000 with blanking on, two full frames
    for (int k = 1; k <= 24; k++) begin
      int p;
      logic [2:0] a_e;
      logic [6:0] s_e;
      step();
      p   = (k - 1) % 12;
      a_e = (p < 4) ? 3'b110 : (p < 8) ? 3'b101 : 3'b011;
      s_e = (p < 4) ? 7'h40 : 7'h7F;
      chk("idle_scan", a_e, s_e);
      chk_fd("idle_fd", p == 10);
    end

    // 305 with blanking off, loaded mid-frame
    blank_lz_wr = 1'b1; blank_lz_in = 1'b0;
    step();
    blank_lz_wr = 1'b0;
    bcd = 12'h305; load = 1'b1;
    step();
    load = 1'b0;
    run_to(29); chk("old_tens", 3'b101, 7'h40);
    run_to(36); chk("old_hund", 3'b011, 7'h40);
    run_to(37); chk("305_ones", 3'b110, 7'h12);
    run_to(41); chk("305_tens", 3'b101, 7'h40);
    run_to(45); chk("305_hund", 3'b011, 7'h30);

    // 007 with blanking on, then blanking turned off mid-slot
    run_to(48);
    bcd = 12'h007; load = 1'b1; blank_lz_wr = 1'b1; blank_lz_in = 1'b1;
    step();
    load = 1'b0; blank_lz_wr = 1'b0;
    run_to(60); chk("hold_305", 3'b011, 7'h30);
    run_to(61); chk("007_ones", 3'b110, 7'h78);
    run_to(65); chk("007_tens", 3'b101, 7'h7F);
    run_to(66);
    blank_lz_wr = 1'b1; blank_lz_in = 1'b0;
    step();
    blank_lz_wr = 1'b0;
    chk("lz_wr_lat", 3'b101, 7'h7F);
    step();
    chk("lz_off_tens", 3'b101, 7'h40);
    run_to(69); chk("lz_off_hund", 3'b011, 7'h40);
    blank_lz_wr = 1'b1; blank_lz_in = 1'b1;
    step();
    blank_lz_wr = 1'b0;

    // Error nibble and all-zero with blanking
    run_to(72);
    bcd = 12'hA42; load = 1'b1;
    step();
    load = 1'b0;
    run_to(85); chk("a42_ones", 3'b110, 7'h24);
    run_to(89); chk("a42_tens", 3'b101, 7'h19);
    run_to(93); chk("a42_hund", 3'b011, 7'h3F);
    run_to(96);
    bcd = 12'h000; load = 1'b1;
    step();
    load = 1'b0;
    run_to(109); chk("000_ones", 3'b110, 7'h40);
    run_to(113); chk("000_tens", 3'b101, 7'h7F);
    run_to(117); chk("000_hund", 3'b011, 7'h7F);

    // Two loads in a frame, then a third on the boundary cycle
    run_to(120);
    bcd = 12'h111; load = 1'b1;
    step();
    load = 1'b0;
    chk("no_early", 3'b110, 7'h40);
    run_to(124);
    bcd = 12'h222; load = 1'b1;
    step();
    load = 1'b0;
    run_to(131);
    chk_fd("bnd_fd", 1'b1);
    bcd = 12'h333; load = 1'b1;
    step();
    load = 1'b0;
    run_to(133); chk("333_ones", 3'b110, 7'h30);
    run_to(137); chk("333_tens", 3'b101, 7'h30);
    run_to(141); chk("333_hund", 3'b011, 7'h30);
    run_to(145); chk("no_stale_ones", 3'b110, 7'h30);
    run_to(149); chk("no_stale_tens", 3'b101, 7'h30);

    // Asynchronous reset during the tens slot
    run_to(150);
    rst = 1'b1;
    #1;
    chk("async_rst", 3'b111, 7'h7F);
    chk_fd("async_rst_fd", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    step();     chk("post_rst_ones", 3'b110, 7'h40);
    run_to(5);  chk("post_rst_tens", 3'b101, 7'h7F);
    run_to(13); chk("post_rst_frame", 3'b110, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Consumes the 3-digit packed BCD word from the binary-to-decimal converter and drives a 3-digit, time-multiplexed, common-anode seven-segment display.
- Holds a pending/display double buffer so a digit update never lands mid-frame.
- Provides optional leading-zero blanking and an error glyph for any nibble above 9. The converter emits such nibbles for inputs above 999.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit; legal range 2..2^20.
- BLANK_LZ_DEFAULT, 1: value of the blanking-enable register after reset.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bcd  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones
- load  input  1  single-cycle strobe; captures bcd into the pending buffer
- blank_lz_wr  input  1  write strobe for the blanking-enable register
- blank_lz_in  input  1  new blanking-enable value, taken when blank_lz_wr=1
- seg  output  7  active-low segments {g,f,e,d,c,b,a}
- an  output  3  active-low anodes; an[0]=ones, an[1]=tens, an[2]=hundreds
- frame_done  output  1  one-cycle pulse when the hundreds slot ends

Behaviour:
- Reset (async assert, sync release) clears the following state:
  - div_cnt=0, idx=0, pending=0, pending_valid=0, disp=0.
  - blank_lz=BLANK_LZ_DEFAULT.
  - seg=7'h7F, an=3'b111, frame_done=0.
- Reset mid-frame discards pending and displayed data immediately.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and then wraps. The wrap cycle is the "tick".
- Scan FSM: states DIG0 -> DIG1 -> DIG2 -> DIG0, advancing on tick only.
- A tick in DIG2 is the frame boundary. On a frame boundary:
  - frame_done=1 for exactly that cycle;
  - if pending_valid: disp<=pending and pending_valid<=0.
- load=1 sets pending<=bcd and pending_valid<=1. A later load before the boundary overwrites pending; the last one wins.
- load on the same cycle as a frame boundary bypasses pending: disp<=bcd and pending_valid<=0.
- blank_lz_wr takes effect on the next cycle. It is not buffered to the frame.
- Digit glyph for the digit selected by idx, taken from disp:
  - 0-9 active-low codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble 10-15: dash = 7'h3F.
  - Blanked digit: 7'h7F.
- Leading-zero blanking applies only when blank_lz=1:
  - hundreds is blank if it is 0;
  - tens is blank if hundreds=0 and tens=0;
  - ones is never blanked, so 000 shows "0".
  - Error nibbles are never blanked.
- Output timing:
  - seg and an are registered and reflect idx/disp/blank_lz one cycle later.
  - An idx change shows on an after one cycle.
  - Exactly one anode is low at any time after the first post-reset edge; no glitch cycle has two anodes low.
- Latency: for a load not on a boundary, the value appears at the first DIG0 after the next frame boundary, plus one output cycle.
- Widths: div_cnt is sized as clog2(REFRESH_DIV) bits. idx is 2 bits and never takes the value 3. If idx is ever 3, the FSM forces DIG0.

Test Plan (REFRESH_DIV=4):
- Reset then release with no load: first edge gives an=110, seg=40. Each anode then stays low for 4 cycles in the order 110, 101, 011. frame_done pulses every 12 cycles.
- Load bcd=12'h305 with blank_lz=0 mid-frame: the display is unchanged until the boundary. The next frame shows ones=12, tens=40, hundreds=30.
- Load 12'h007 with blank_lz=1: hundreds and tens slots show 7F and ones shows 78. After a blank_lz_wr to 0, the next cycle shows the tens slot as 40.
- Load 12'hA42 (input above 999), then 12'h000 with blank_lz=1:
  - 12'hA42 gives hundreds=3F (not blanked), tens=19, ones=24;
  - 12'h000 gives 7F, 7F, 40.
- Load two values in one frame (12'h111, then 12'h222), with a third load 12'h333 on the exact boundary cycle. Required display order is 333; 111 and 222 are never shown, and pending_valid is 0 afterward.
- Assert rst during DIG1 with data displayed: outputs go to an=111 and seg=7F asynchronously. After release, the display shows 0 (ones=40) and no stale pending is applied.
